pet2001_prg_loader: RTL and testbench
=====================================

// Module: pet2001_prg_loader
// PURPOSE
//  DMA initiator that streams a .PRG image from the host download channel into the PET RAM over
//  the dma_addr/dma_din/dma_we port of the PET hardware block.
//  Parses the 2-byte little-endian load-address header, then writes payload bytes sequentially.
//  Rejects writes at or above RAM_TOP, so injection never reaches the ROM/IO space.
//  Reports busy/done/error to the top level.
// PARAMETERS
//  RAM_TOP   16'h8000  first address not writable; payload bytes at >= RAM_TOP are dropped
//  PTR_BASE  8'h2A     zero-page address of VARTAB; ARYTAB = +2, STREND = +4 (fixup only)
// PORTS
//  clk         in   1   system clock; the only clock
//  reset       in   1   synchronous, active-high reset
//  dl_active   in   1   high for the whole duration of a host download
//  dl_wr       in   1   one-cycle strobe: dl_data valid; at most one byte per clk
//  dl_data     in   8   download byte
//  dl_wait     out  1   host must hold off dl_wr and new downloads while high
//  dma_addr    out  16  DMA write address
//  dma_din     out  8   DMA write data
//  dma_we      out  1   one-cycle DMA write strobe
//  busy        out  1   high from download start until DONE/IDLE
//  done        out  1   sticky: last load completed without error
//  error       out  1   sticky: last load short-header or out-of-range
// BEHAVIOUR
//  Reset: state IDLE; dma_addr=0, dma_din=0, dma_we=0, dl_wait=0, busy=0, done=0, error=0.
//  Start = rising edge of dl_active (registered): clears done/error, sets busy, goes to HDR_LO.
//  States: IDLE, HDR_LO, HDR_HI, DATA, FIX, DONE.
//   HDR_LO: dl_wr -> load_addr[7:0]=dl_data, go to HDR_HI.
//   HDR_HI: dl_wr -> load_addr[15:8]=dl_data, ptr=load_addr, go to DATA.
//   DATA: dl_wr -> next clk: dma_we=1, dma_addr=ptr, dma_din=byte; ptr<=ptr+1. Latency = 1 clk.
//     If ptr>=RAM_TOP, or ptr wrapped past FFFF (17-bit compare): no dma_we, error=1, byte dropped.
//     Rest of the stream is still consumed, writes stay suppressed.
//   dl_active falls:
//     in HDR_LO/HDR_HI -> error=1, no writes, go to DONE;
//     in DATA -> FIX if compiled in and no error, else DONE.
//   A dl_wr in the same clk as the dl_active fall is accepted and written before the state changes.
//   FIX: dl_wait=1. Six consecutive dma_we pulses, one per clk, in order:
//     PTR_BASE+0..+5 <= end_lo,end_hi ×3, where end=ptr (first free byte).
//     Then go to DONE.
//   DONE: busy=0, done=~error for 1 clk then IDLE (done/error stay sticky until next start).
//  dma_we is never asserted in IDLE/HDR_*/DONE; dma_addr/dma_din hold last value when dma_we=0.
//  Start seen during FIX: latched pending; FIX finishes all 6 writes, then HDR_LO (skips DONE).
//  Start seen in HDR_*/DATA (glitch re-assert): restart at HDR_LO; bytes already written remain.
//  reset mid-operation: immediate return to reset values; no further dma_we.
//  Zero-length payload (header only): no data writes; FIX writes end=load_addr.
// CONFIGURATION
//  PRG_PTR_FIXUP_EN defined:
//    FIX state present; BASIC VARTAB/ARYTAB/STREND are patched so RUN works after injection.
//  PRG_PTR_FIXUP_EN undefined:
//    FIX state absent; DATA -> DONE directly; dl_wait is tied 0; exactly one dma_we per in-range payload byte.
// TESTING
//  1 Stream 01 04 AA BB CC, drop dl_active ->
//      writes 0401=AA, 0402=BB, 0403=CC, 1 clk after each dl_wr;
//      with fixup, 002A..002F = 04 04 04 04 04 04; done=1, error=0.
//  2 Header FE 7F + 4 bytes ->
//      7FFE, 7FFF written; bytes 3-4 produce no dma_we;
//      error=1, done=0, no fixup writes.
//  3 dl_active high, one byte 01, then low ->
//      zero dma_we, error=1, busy returns 0.
//  4 Back-to-back dl_wr every clk, 256 bytes at 0401 ->
//      256 contiguous dma_we, last addr 0500; fixup end=0501 (2A=01, 2B=05).
//  5 Assert reset mid-DATA after 10 bytes ->
//      dma_we=0 next clk, all outputs at reset values, state IDLE.
//  6 New dl_active rise during FIX ->
//      all 6 fixup writes complete, then next header parsed correctly; done/error cleared at start.

Source files
------------

// File: rtl/pet2001_prg_loader.sv
// Streams a .PRG download (2-byte load address + payload) into PET RAM via the DMA write port.
// Optional BASIC pointer patch-up after the payload is built when PRG_PTR_FIXUP_EN is defined.
module pet2001_prg_loader #(
  parameter logic [15:0] RAM_TOP  = 16'h8000,
  parameter logic [7:0]  PTR_BASE = 8'h2A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, FIX, DONE} state_t;

  state_t      state;
  logic        act_q;
  logic [7:0]  load_lo;
  logic [16:0] ptr;
`ifdef PRG_PTR_FIXUP_EN
  logic [2:0]  fix_idx;
  logic        start_pend;
`endif

  logic start, fall, in_range, data_bad;
  assign start    = dl_active & ~act_q;
  assign fall     = ~dl_active & act_q;
  // 17-bit pointer so a wrap past FFFF still compares as out of range
  assign in_range = (ptr < {1'b0, RAM_TOP});
  assign data_bad = error | (dl_wr & ~in_range);

`ifndef PRG_PTR_FIXUP_EN
  assign dl_wait = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      act_q    <= 1'b0;
      load_lo  <= 8'h00;
      ptr      <= 17'h0;
      dma_addr <= 16'h0;
      dma_din  <= 8'h00;
      dma_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef PRG_PTR_FIXUP_EN
      dl_wait    <= 1'b0;
      fix_idx    <= 3'd0;
      start_pend <= 1'b0;
`endif
    end else begin
      act_q  <= dl_active;
      dma_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= HDR_LO;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        HDR_LO: begin
          if (start) begin
            state <= HDR_LO;
            done  <= 1'b0;
            error <= 1'b0;
          end else if (fall) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b1;
          end else if (dl_wr) begin
            load_lo <= dl_data;
            state   <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (start) begin
            state <= HDR_LO;
            done  <= 1'b0;
            error <= 1'b0;
          end else if (dl_wr) begin
            ptr <= {1'b0, dl_data, load_lo};
            if (fall) begin
`ifdef PRG_PTR_FIXUP_EN
              state   <= FIX;
              dl_wait <= 1'b1;
`else
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end else if (fall) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b1;
          end
        end
        DATA: begin
          if (start) begin
            state <= HDR_LO;
            done  <= 1'b0;
            error <= 1'b0;
          end else begin
            if (dl_wr) begin
              ptr <= ptr + 17'd1;
              if (in_range && !error) begin
                dma_we   <= 1'b1;
                dma_addr <= ptr[15:0];
                dma_din  <= dl_data;
              end else begin
                error <= 1'b1;
              end
            end
            if (fall) begin
`ifdef PRG_PTR_FIXUP_EN
              if (!data_bad) begin
                state   <= FIX;
                dl_wait <= 1'b1;
              end else
`endif
              begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= ~data_bad;
              end
            end
          end
        end
`ifdef PRG_PTR_FIXUP_EN
        FIX: begin
          // VARTAB, ARYTAB, STREND all point at the first free byte after the program
          dma_we   <= 1'b1;
          dma_addr <= {8'h00, PTR_BASE + {5'b0, fix_idx}};
          dma_din  <= fix_idx[0] ? ptr[15:8] : ptr[7:0];
          if (start) start_pend <= 1'b1;
          if (fix_idx == 3'd5) begin
            fix_idx    <= 3'd0;
            dl_wait    <= 1'b0;
            start_pend <= 1'b0;
            if (start_pend || start) begin
              state <= HDR_LO;
              done  <= 1'b0;
              error <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            fix_idx <= fix_idx + 3'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pet2001_prg_loader.sv
// Randomized and directed PRG loads compared against a list-based model of the expected RAM writes.
module tb_pet2001_prg_loader;
  logic        clk = 1'b0;
  logic        reset, dl_active, dl_wr, dl_wait, dma_we, busy, done, error;
  logic [7:0]  dl_data, dma_din;
  logic [15:0] dma_addr;

  pet2001_prg_loader dut (
    .clk(clk), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_data(dl_data),
    .dl_wait(dl_wait), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [23:0] capq[$];
  int          capc[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) if (dma_we) begin
    capq.push_back({dma_addr, dma_din});
    capc.push_back(cyc);
  end

  logic [7:0]  strm[$];
  bit          bytewr[$];
  logic [23:0] exp_q[$];
  bit          exp_err;
`ifdef PRG_PTR_FIXUP_EN
  localparam bit FIXUP = 1'b1;
`else
  localparam bit FIXUP = 1'b0;
`endif

  // Expected RAM writes for the current stream: in-range payload bytes in order, then the pointer patch.
  task automatic build_exp(input bit append);
    int p;
    if (!append) exp_q = {};
    bytewr = {};
    exp_err = 1'b0;
    foreach (strm[i]) bytewr.push_back(1'b0);
    if (strm.size() < 2) begin
      exp_err = 1'b1;
      return;
    end
    p = {16'h0, strm[1], strm[0]};
    for (int i = 2; i < strm.size(); i++) begin
      if (!exp_err && p < 'h8000) begin
        exp_q.push_back({p[15:0], strm[i]});
        bytewr[i] = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
      p++;
    end
    if (FIXUP && !exp_err)
      for (int k = 0; k < 6; k++)
        exp_q.push_back({16'h002A + 16'(k), (k % 2 == 1) ? p[15:8] : p[7:0]});
  endtask

  task automatic send_bytes(input int n, input bit same_fall, input int maxgap);
    int base;
    base = (strm.size() >= 2) ? {16'h0, strm[1], strm[0]} : 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      dl_wr   = 1'b1;
      dl_data = strm[i];
      if (same_fall && i == n - 1) dl_active = 1'b0;
      @(negedge clk);
      dl_wr = 1'b0;
      chk("lat_we", dma_we, bytewr[i]);
      if (bytewr[i]) begin
        chk("lat_addr", dma_addr, (base + i - 2) & 'hFFFF);
        chk("lat_din", dma_din, strm[i]);
      end
    end
    dl_active = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (!busy && !dl_wait) ok = 1'b1;
    end
    chk("idle_reached", ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    int n;
    chk({tag, "_nwr"}, capq.size(), exp_q.size());
    n = (capq.size() < exp_q.size()) ? capq.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, capq[i], exp_q[i]);
    if (FIXUP && !exp_err && capq.size() >= 6)
      chk({tag, "_fixgap"}, capc[capc.size()-1] - capc[capc.size()-6], 5);
    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_load(input string tag, input bit same_fall, input int maxgap);
    build_exp(1'b0);
    capq = {};
    capc = {};
    @(negedge clk);
    dl_active = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_start"}, busy, 1);
    send_bytes(strm.size(), same_fall, maxgap);
    wait_idle();
    compare_all(tag);
  endtask

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", dma_we, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_din", dma_din, 0);
    chk("rst_flags", {dl_wait, busy, done, error}, 0);
    reset = 1'b0;
    @(negedge clk);

    strm = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_load("basic", 1'b0, 2);
    strm = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load("top", 1'b0, 1);
    strm = '{8'h01};
    run_load("short", 1'b0, 0);
    strm = '{8'h00, 8'h10};
    run_load("zerolen", 1'b0, 0);
    strm = '{8'h01, 8'h04};
    for (int i = 0; i < 256; i++) strm.push_back(8'($urandom));
    run_load("b2b", 1'b0, 0);
    strm = '{8'h10, 8'h20, 8'h5A, 8'hA5, 8'h3C};
    run_load("samefall", 1'b1, 0);

    // reset in the middle of a payload
    strm = '{8'h01, 8'h04};
    for (int i = 0; i < 20; i++) strm.push_back(8'($urandom));
    build_exp(1'b0);
    capq = {};
    @(negedge clk);
    dl_active = 1'b1;
    @(negedge clk);
    send_bytes(12, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we", dma_we, 0);
    chk("midrst_addr", dma_addr, 0);
    chk("midrst_din", dma_din, 0);
    chk("midrst_flags", {dl_wait, busy, done, error}, 0);
    chk("midrst_nwr", capq.size(), 10);
    for (int i = 0; i < 10 && i < capq.size(); i++) chk("midrst_wr", capq[i], exp_q[i]);
    reset = 1'b0;
    repeat (2) @(negedge clk);

`ifdef PRG_PTR_FIXUP_EN
    begin
      bit seen;
      strm = '{8'h00, 8'h30, 8'h01, 8'h02, 8'h03};
      build_exp(1'b0);
      capq = {};
      capc = {};
      @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
      send_bytes(strm.size(), 1'b0, 0);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        seen = dl_wait;
      end
      chk("pend_wait_hi", seen, 1);
      dl_active = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = !dl_wait;
      end
      chk("pend_wait_lo", seen, 1);
      chk("pend_busy", busy, 1);
      chk("pend_cleared", {done, error}, 0);
      strm = '{8'h40, 8'h06, 8'hDE, 8'hAD};
      build_exp(1'b1);
      send_bytes(strm.size(), 1'b0, 1);
      wait_idle();
      compare_all("pend");
    end
`endif

    for (int t = 0; t < 8; t++) begin
      int a, len;
      case ($urandom_range(2, 0))
        0: a = $urandom_range('h7000, 'h0400);
        1: a = 'h7FE0 + $urandom_range(31, 0);
        default: a = 'hFFF0 + $urandom_range(15, 0);
      endcase
      len = $urandom_range(40, 0);
      strm = {};
      strm.push_back(a[7:0]);
      strm.push_back(a[15:8]);
      for (int i = 0; i < len; i++) strm.push_back(8'($urandom));
      run_load("rnd", 1'($urandom_range(1, 0)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
